// File: rtl/rs75_encoder.sv
`timescale 1ns/1ps
// Symbol-serial systematic RS(7,5) encoder over GF(2^3): one-cycle registered latency from input to output.
// Output register stalls when out_valid && !out_ready; in_ready drops during stalls and while parity is emitted.

`ifndef N
`define N 7
`endif
`ifndef SYMBOL_WIDTH
`define SYMBOL_WIDTH 3
`endif

module rs75_encoder (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               in_valid,
    output logic                               in_ready,
    input  logic [`SYMBOL_WIDTH-1:0]           in_data,
    output logic                               out_valid,
    input  logic                               out_ready,
    output logic [`SYMBOL_WIDTH-1:0]           out_data,
    output logic                               out_last,
    output logic                               cw_valid,
    output logic [`N*`SYMBOL_WIDTH-1:0]        cw
);

    localparam int SW = `SYMBOL_WIDTH;
    localparam int K  = 5;
    localparam int CW = `N * `SYMBOL_WIDTH;

    typedef enum logic [1:0] {
        ST_MSG  = 2'd0,
        ST_PAR1 = 2'd1,
        ST_PAR0 = 2'd2
    } state_t;

    // Constant multiply in GF(8), reduction by x^3 + x + 1.
    function automatic logic [SW-1:0] gf_mul(input logic [SW-1:0] a, input logic [SW-1:0] b);
        logic [SW-1:0] p;
        logic [SW-1:0] x;
        p = '0;
        x = a;
        for (int i = 0; i < SW; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[SW-2:0], 1'b0} ^ (x[SW-1] ? 3'b011 : 3'b000);
        end
        return p;
    endfunction

    function automatic logic [SW-1:0] gf_add(input logic [SW-1:0] a, input logic [SW-1:0] b);
        return a ^ b;
    endfunction

    state_t              r_state;
    logic [2:0]          r_cnt;
    logic [SW-1:0]       r_r1;
    logic [SW-1:0]       r_r0;
    logic [K*SW-1:0]     r_shadow;
    logic [SW-1:0]       r_out_data;
    logic                r_out_valid;
    logic                r_out_last;
    logic                r_cw_valid;
    logic [CW-1:0]       r_cw;

    logic                w_adv;
    logic                w_in_ready;
    logic                w_accept;
    logic [SW-1:0]       w_fb;
    logic [SW-1:0]       w_r1_nxt;
    logic [SW-1:0]       w_r0_nxt;

    assign w_adv      = !r_out_valid || out_ready;
    assign w_in_ready = (r_state == ST_MSG) && w_adv;
    assign w_accept   = in_valid && w_in_ready;

    // Division by g(x) = x^2 + 6x + 3, remainder held in r1:r0.
    assign w_fb       = gf_add(in_data, r_r1);
    assign w_r1_nxt   = gf_add(r_r0, gf_mul(w_fb, 3'd6));
    assign w_r0_nxt   = gf_mul(w_fb, 3'd3);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_MSG;
            r_cnt       <= '0;
            r_r1        <= '0;
            r_r0        <= '0;
            r_shadow    <= '0;
            r_out_data  <= '0;
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
            r_cw_valid  <= 1'b0;
            r_cw        <= '0;
        end else begin
            r_cw_valid <= 1'b0;
            case (r_state)
                ST_MSG: begin
                    if (w_accept) begin
                        r_out_data  <= in_data;
                        r_out_valid <= 1'b1;
                        r_out_last  <= 1'b0;
                        r_r1        <= w_r1_nxt;
                        r_r0        <= w_r0_nxt;
                        r_shadow    <= {r_shadow[(K-1)*SW-1:0], in_data};
                        if (r_cnt == 3'd4) begin
                            r_cnt   <= '0;
                            r_state <= ST_PAR1;
                        end else begin
                            r_cnt   <= r_cnt + 3'd1;
                        end
                    end else if (r_out_valid && out_ready) begin
                        r_out_valid <= 1'b0;
                        r_out_last  <= 1'b0;
                    end
                end
                ST_PAR1: begin
                    if (w_adv) begin
                        r_out_data  <= r_r1;
                        r_out_valid <= 1'b1;
                        r_out_last  <= 1'b0;
                        r_state     <= ST_PAR0;
                    end
                end
                ST_PAR0: begin
                    if (w_adv) begin
                        r_out_data  <= r_r0;
                        r_out_valid <= 1'b1;
                        r_out_last  <= 1'b1;
                        r_cw        <= {r_shadow, r_r1, r_r0};
                        r_cw_valid  <= 1'b1;
                        r_r1        <= '0;
                        r_r0        <= '0;
                        r_shadow    <= '0;
                        r_state     <= ST_MSG;
                    end
                end
                default: begin
                    r_state <= ST_MSG;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

    assign in_ready  = w_in_ready;
    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_last  = r_out_last;
    assign cw_valid  = r_cw_valid;
    assign cw        = r_cw;

endmodule

// File: tb/tb_rs75_encoder.sv
`timescale 1ns/1ps
// Bench for rs75_encoder: polynomial-division reference model, stream scoreboard and syndrome checks.

module tb_rs75_encoder;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  in_data;
    logic        out_valid;
    logic        out_ready;
    logic [2:0]  out_data;
    logic        out_last;
    logic        cw_valid;
    logic [20:0] cw;

    rs75_encoder dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last),
        .cw_valid  (cw_valid),
        .cw        (cw)
    );

    always #5 clk = ~clk;

    int          n_cmp = 0;
    int          n_err = 0;
    int          cyc = 0;
    int          cw_pulses = 0;
    int          cw_expected = 0;
    bit          rand_rdy = 1'b0;
    logic [2:0]  exp_sym[$];
    logic        exp_last[$];
    logic [20:0] exp_cw[$];
    int          cw_times[$];
    logic        stall = 1'b0;
    logic [2:0]  prev_data;
    logic        prev_last;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, expv, cyc);
        end
    endtask

    function automatic logic [2:0] alog(input int e);
        case (e % 7)
            0: return 3'd1;
            1: return 3'd2;
            2: return 3'd4;
            3: return 3'd3;
            4: return 3'd6;
            5: return 3'd7;
            default: return 3'd5;
        endcase
    endfunction

    function automatic int lg(input logic [2:0] a);
        for (int e = 0; e < 7; e++) if (alog(e) == a) return e;
        return 0;
    endfunction

    function automatic logic [2:0] gmul(input logic [2:0] a, input logic [2:0] b);
        if (a == 0 || b == 0) return 3'd0;
        return alog(lg(a) + lg(b));
    endfunction

    // Systematic codeword: message then remainder of m(x)*x^2 divided by x^2 + 6x + 3.
    function automatic logic [20:0] enc(input logic [14:0] m);
        logic [2:0] p [7];
        logic [2:0] coef;
        for (int i = 0; i < 5; i++) p[6-i] = m[14-3*i -: 3];
        p[1] = 3'd0;
        p[0] = 3'd0;
        for (int d = 6; d >= 2; d--) begin
            coef   = p[d];
            p[d]   = 3'd0;
            p[d-1] = p[d-1] ^ gmul(coef, 3'd6);
            p[d-2] = p[d-2] ^ gmul(coef, 3'd3);
        end
        return {m, p[1], p[0]};
    endfunction

    function automatic logic [2:0] syn(input logic [20:0] c, input int j);
        logic [2:0] s;
        s = 3'd0;
        for (int i = 0; i < 7; i++) s = s ^ gmul(c[3*i +: 3], alog(j * i));
        return s;
    endfunction

    task automatic push_expected(input logic [14:0] m);
        logic [20:0] c;
        c = enc(m);
        for (int k = 0; k < 7; k++) begin
            exp_sym.push_back(c[20-3*k -: 3]);
            exp_last.push_back(k == 6);
        end
        exp_cw.push_back(c);
        cw_expected++;
    endtask

    always @(posedge clk) cyc++;

    always @(posedge clk) begin
        #1;
        out_ready = rand_rdy ? ($urandom_range(0, 1) == 1) : 1'b1;
    end

    always @(negedge clk) begin
        if (rst) begin
            stall = 1'b0;
        end else begin
            if (stall) begin
                check("stall_valid", {31'd0, out_valid}, 32'd1);
                check("stall_data", {29'd0, out_data}, {29'd0, prev_data});
                check("stall_last", {31'd0, out_last}, {31'd0, prev_last});
            end
            if (out_valid && out_ready) begin
                if (exp_sym.size() == 0) begin
                    check("extra_symbol", {29'd0, out_data}, 32'hffff_ffff);
                end else begin
                    check("out_data", {29'd0, out_data}, {29'd0, exp_sym.pop_front()});
                    check("out_last", {31'd0, out_last}, {31'd0, exp_last.pop_front()});
                end
            end
            stall     = out_valid && !out_ready;
            prev_data = out_data;
            prev_last = out_last;
            if (cw_valid) begin
                cw_pulses++;
                cw_times.push_back(cyc);
                if (exp_cw.size() == 0) check("extra_cw", {11'd0, cw}, 32'hffff_ffff);
                else check("cw", {11'd0, cw}, {11'd0, exp_cw.pop_front()});
                check("cw_s1", {29'd0, syn(cw, 1)}, 32'd0);
                check("cw_s2", {29'd0, syn(cw, 2)}, 32'd0);
            end
        end
    end

    task automatic send_msg(input logic [14:0] m, input int maxgap, input int nsym);
        int t;
        for (int i = 0; i < nsym; i++) begin
            in_valid = 1'b0;
            repeat ($urandom_range(0, maxgap)) begin
                @(posedge clk);
                #1;
            end
            in_valid = 1'b1;
            in_data  = m[14-3*i -: 3];
            t = 0;
            @(negedge clk);
            while (!in_ready && t < 500) begin
                @(negedge clk);
                t++;
            end
            if (!in_ready) check("accept_timeout", {31'd0, in_ready}, 32'd1);
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int t;
        t = 0;
        while (exp_sym.size() != 0 && t < 3000) begin
            @(posedge clk);
            #1;
            t++;
        end
        check("drain_empty", exp_sym.size(), 32'd0);
        repeat (2) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        logic [29:0] stream;
        int          a;
        logic [14:0] m;

        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = 3'd0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_out_last", {31'd0, out_last}, 32'd0);
        check("rst_cw_valid", {31'd0, cw_valid}, 32'd0);
        check("rst_out_data", {29'd0, out_data}, 32'd0);
        check("rst_cw", {11'd0, cw}, 32'd0);
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        @(posedge clk);
        #1;

        // Hand-computed values pinning the reference model.
        check("model_lead", {11'd0, enc(15'o10000)}, {11'd0, 21'o1000062});
        check("model_trail", {11'd0, enc(15'o00001)}, {11'd0, 21'o0000163});
        check("model_zero", {11'd0, enc(15'o00000)}, 32'd0);
        check("model_s1", {29'd0, syn(21'o1000062, 1)}, 32'd0);
        check("model_s2", {29'd0, syn(21'o0000163, 2)}, 32'd0);

        push_expected(15'o00000);
        send_msg(15'o00000, 0, 5);
        drain();
        check("zero_pulses", cw_pulses, 32'd1);
        check("zero_cw", {11'd0, cw}, 32'd0);

        push_expected(15'o10000);
        send_msg(15'o10000, 0, 5);
        drain();
        check("lead_cw", {11'd0, cw}, {11'd0, 21'o1000062});

        push_expected(15'o00001);
        send_msg(15'o00001, 0, 5);
        drain();
        check("trail_cw", {11'd0, cw}, {11'd0, 21'o0000163});

        // Abort a codeword after three symbols.
        push_expected(15'o12345);
        cw_expected--;
        send_msg(15'o12345, 0, 3);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        exp_sym.delete();
        exp_last.delete();
        exp_cw.delete();
        @(negedge clk);
        check("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("mid_rst_out_last", {31'd0, out_last}, 32'd0);
        check("mid_rst_out_data", {29'd0, out_data}, 32'd0);
        check("mid_rst_cw_valid", {31'd0, cw_valid}, 32'd0);
        check("mid_rst_cw", {11'd0, cw}, 32'd0);
        @(posedge clk);
        #1;
        push_expected(15'o10000);
        send_msg(15'o10000, 0, 5);
        drain();
        check("post_rst_cw", {11'd0, cw}, {11'd0, 21'o1000062});

        // Back-to-back codewords with continuous input.
        stream = {15'o76543, 15'o21076};
        push_expected(stream[29:15]);
        push_expected(stream[14:0]);
        a = 0;
        for (int c = 0; c < 14; c++) begin
            in_valid = (a < 10);
            in_data  = (a < 10) ? stream[29-3*a -: 3] : 3'd0;
            @(negedge clk);
            check("b2b_in_ready", {31'd0, in_ready}, {31'd0, (c % 7) < 5});
            if (in_valid && in_ready) a++;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        drain();
        check("b2b_accepted", a, 32'd10);
        if (cw_times.size() >= 2)
            check("b2b_cw_spacing", cw_times[cw_times.size()-1] - cw_times[cw_times.size()-2], 32'd7);
        else
            check("b2b_cw_count", cw_times.size(), 32'd2);

        // Random backpressure and input gaps.
        rand_rdy = 1'b1;
        for (int n = 0; n < 200; n++) begin
            m = 15'($urandom);
            push_expected(m);
            send_msg(m, 3, 5);
        end
        rand_rdy = 1'b0;
        drain();
        check("total_cw_pulses", cw_pulses, cw_expected);
        check("cw_queue_empty", exp_cw.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got timeout, expected completion");
        $fatal(1);
    end

endmodule
